// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the instruction/data cache memory arbiter:
//   - default LINE_WORDS / ADDR_W / DATA_W values used by mem_arbiter
//   - FSM state encoding (IDLE, BURST_I, BURST_D, DONE)
//   - burst owner encoding shared by the arbiter and the top level
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BURST_I = 2'd1;
  localparam logic [1:0] ST_BURST_D = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic logic is_burst(input logic [1:0] st);
    return (st == ST_BURST_I) || (st == ST_BURST_D);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter between the instruction cache (I) and the data
// cache (D). Grants are combinational and only produced while en is high; the
// last_grant register remembers the most recent winner so that a tie goes to
// the other requester. last_grant resets to I, so D wins the first tie.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   en     in   arbitration enable (high only while the FSM is idle)
//   req_i  in   instruction-cache request
//   req_d  in   data-cache request
//   gnt_i  out  grant to the instruction cache
//   gnt_d  out  grant to the data cache
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  owner_e last_grant_q;
  owner_e last_grant_d;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (req_i && req_d) begin
        // Tie: favour whoever did not win last time.
        if (last_grant_q == OWN_I) begin
          gnt_d = 1'b1;
        end else begin
          gnt_i = 1'b1;
        end
      end else begin
        gnt_i = req_i;
        gnt_d = req_d;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_i) begin
      last_grant_d = OWN_I;
    end else if (gnt_d) begin
      last_grant_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OWN_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one word-wide backing memory between an instruction-cache line fill
// port and a data-cache fill/write-back port. Each granted request becomes a
// LINE_WORDS-word sequential burst starting at the line base address; one
// word moves per mem_ack. A one-cycle DONE state pulses the owner's done and
// forces at least one idle cycle between bursts.
//
// Parameters:
//   LINE_WORDS  words per line burst (power of two, 2..16)
//   ADDR_W      byte address width
//   DATA_W      word width
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   ic_req/ic_addr          instruction fill request and line address
//   ic_rvalid/ic_rdata/ic_widx  instruction fill word return
//   ic_done                 instruction burst complete (1-cycle pulse)
//   dc_req/dc_we/dc_addr    data burst request, direction, line address
//   dc_wdata/dc_widx        write-back word and current word index
//   dc_rvalid/dc_rdata      data fill word return
//   dc_done                 data burst complete (1-cycle pulse)
//   mem_req/mem_we/mem_addr/mem_wdata   backing-memory word request
//   mem_ack/mem_rdata       backing-memory handshake and read data
//   icache_stall/dcache_stall  pipeline stall outputs
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  localparam int IW        = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic [IW-1:0]     ic_widx,
  output logic              ic_done,

  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [IW-1:0]     dc_widx,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              icache_stall,
  output logic              dcache_stall
);

  // Byte-offset bits inside one line: word index plus the 2 byte-lane bits.
  localparam int OFS_W = IW + 2;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;

  logic arb_en;
  logic gnt_i;
  logic gnt_d;
  logic in_burst;
  logic last_word;
  logic rd_beat;

  // Line-offset address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[OFS_W-1:0], dc_addr[OFS_W-1:0]};

  assign arb_en    = (state_q == ST_IDLE);
  assign in_burst  = is_burst(state_q);
  assign last_word = (cnt_q == IW'(LINE_WORDS - 1));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_i (ic_req),
    .req_d (dc_req),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    owner_d = owner_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_i) begin
          state_d = ST_BURST_I;
          base_d  = line_base(ic_addr);
          owner_d = OWN_I;
          we_d    = 1'b0;
          cnt_d   = '0;
        end else if (gnt_d) begin
          state_d = ST_BURST_D;
          base_d  = line_base(dc_addr);
          owner_d = OWN_D;
          we_d    = dc_we;
          cnt_d   = '0;
        end
      end
      ST_BURST_I, ST_BURST_D: begin
        // Requester level is not consulted here: a started burst always
        // runs to completion.
        if (mem_ack) begin
          if (last_word) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      owner_q <= owner_d;
      we_q    <= we_d;
    end
  end

  // Memory-side outputs. Base has its offset bits cleared, so adding the
  // word offset never carries out of the line.
  assign mem_req   = in_burst;
  assign mem_we    = in_burst & we_q;
  assign mem_addr  = in_burst ? (base_q + ADDR_W'({cnt_q, 2'b00})) : '0;
  assign mem_wdata = in_burst ? dc_wdata : '0;

  // Read data is forwarded in the same cycle as mem_ack.
  assign rd_beat   = in_burst & mem_ack & ~we_q;

  assign ic_rvalid = rd_beat & (state_q == ST_BURST_I);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign ic_widx   = ic_rvalid ? cnt_q : '0;

  assign dc_rvalid = rd_beat & (state_q == ST_BURST_D);
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign dc_widx   = cnt_q;

  assign ic_done   = (state_q == ST_DONE) & (owner_q == OWN_I);
  assign dc_done   = (state_q == ST_DONE) & (owner_q == OWN_D);

  // Stalls are combinational from the request; gating with rst keeps every
  // output low while reset is held, even with a request pending.
  assign icache_stall = rst & ic_req & ~ic_done;
  assign dcache_stall = rst & dc_req & ~dc_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios plus a randomized phase for mem_arbiter. A transaction
// level reference model (idle / burst / done phases, burst owner, base and
// word number) predicts every output each cycle; scenario logs are also
// compared against literal expected sequences.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = $clog2(LW);

  logic          clk;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_rvalid;
  logic [DW-1:0] ic_rdata;
  logic [IW-1:0] ic_widx;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [IW-1:0] dc_widx;
  logic          dc_rvalid;
  logic [DW-1:0] dc_rdata;
  logic          dc_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          icache_stall;
  logic          dcache_stall;

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_req       (ic_req),
    .ic_addr      (ic_addr),
    .ic_rvalid    (ic_rvalid),
    .ic_rdata     (ic_rdata),
    .ic_widx      (ic_widx),
    .ic_done      (ic_done),
    .dc_req       (dc_req),
    .dc_we        (dc_we),
    .dc_addr      (dc_addr),
    .dc_wdata     (dc_wdata),
    .dc_widx      (dc_widx),
    .dc_rvalid    (dc_rvalid),
    .dc_rdata     (dc_rdata),
    .dc_done      (dc_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: burst-level view of the arbiter.
  typedef enum {P_IDLE, P_BURST, P_DONE} phase_t;
  phase_t        ph;
  bit            cur_d;      // current owner is the data cache
  bit            cur_we;
  logic [31:0]   cur_base;
  int            k;          // words completed in the current burst
  bit            last_d;     // last winner was the data cache

  // Stimulus controls and observation logs.
  int            ack_mode;   // 0 every cycle, 1 every other cycle, 2 random
  bit            alt;
  bit            rd_rand;
  logic [31:0]   rdata_base;
  int            n_acks;
  bit            auto_drop;
  int            cyc;
  bit            seen_icd, seen_dcd;
  int            ic_done_cyc, d_start_obs, last_ack_cyc;
  int            we_acks, done_cnt;
  bit            dcv_seen;
  logic [31:0]   ack_addr_q[$];
  int            ack_idx_q[$];
  logic [31:0]   rd_data_q[$];
  int            rd_idx_q[$];
  bit            done_order_q[$];

  task automatic model_reset();
    ph     = P_IDLE;
    k      = 0;
    last_d = 1'b0;
  endtask

  task automatic model_update();
    bit gi, gd;
    if (!rst) begin
      model_reset();
      return;
    end
    case (ph)
      P_IDLE: begin
        gi = ic_req;
        gd = dc_req;
        if (gi && gd) begin
          if (last_d) gd = 1'b0;
          else gi = 1'b0;
        end
        if (gi || gd) begin
          ph       = P_BURST;
          cur_d    = gd;
          cur_base = (gd ? dc_addr : ic_addr) & ~32'(LW * 4 - 1);
          cur_we   = gd ? dc_we : 1'b0;
          k        = 0;
          last_d   = gd;
        end
      end
      P_BURST: begin
        if (mem_ack) begin
          if (k == LW - 1) begin
            ph = P_DONE;
            k  = 0;
          end else begin
            k++;
          end
        end
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    bit          burst, done, rd;
    bit          e_icv, e_dcv, e_icd, e_dcd;
    logic [31:0] e_addr;
    burst  = rst && (ph == P_BURST);
    done   = rst && (ph == P_DONE);
    rd     = burst && mem_ack && !cur_we;
    e_icv  = rd && !cur_d;
    e_dcv  = rd && cur_d;
    e_icd  = done && !cur_d;
    e_dcd  = done && cur_d;
    e_addr = burst ? cur_base + 32'(4 * k) : 32'h0;
    chk("mem_req",   64'(mem_req),   64'(burst));
    chk("mem_we",    64'(mem_we),    64'(burst && cur_we));
    chk("mem_addr",  64'(mem_addr),  64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), burst ? 64'(dc_wdata) : 64'h0);
    chk("ic_rvalid", 64'(ic_rvalid), 64'(e_icv));
    chk("dc_rvalid", 64'(dc_rvalid), 64'(e_dcv));
    chk("ic_done",   64'(ic_done),   64'(e_icd));
    chk("dc_done",   64'(dc_done),   64'(e_dcd));
    chk("dc_widx",   64'(dc_widx),   burst ? 64'(k) : 64'h0);
    chk("icache_stall", 64'(icache_stall), 64'(rst && ic_req && !e_icd));
    chk("dcache_stall", 64'(dcache_stall), 64'(rst && dc_req && !e_dcd));
    if (e_icv) begin
      chk("ic_rdata", 64'(ic_rdata), 64'(mem_rdata));
      chk("ic_widx",  64'(ic_widx),  64'(k));
    end
    if (e_dcv) begin
      chk("dc_rdata", 64'(dc_rdata), 64'(mem_rdata));
    end
  endtask

  // One clock cycle: memory responds at the falling edge, outputs are checked
  // just after, the model advances on the rising edge.
  task automatic step();
    @(negedge clk);
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       begin mem_ack = alt; alt = !alt; end
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
    end
    mem_rdata = rd_rand ? 32'($urandom) : rdata_base + 32'(n_acks);
    if (mem_ack) n_acks++;
    dc_wdata = 32'($urandom);
    #1;
    check_outputs();
    if (mem_ack && mem_req) begin
      ack_addr_q.push_back(mem_addr);
      ack_idx_q.push_back(int'(dc_widx));
      last_ack_cyc = cyc;
      if (mem_we) we_acks++;
    end
    if (ic_rvalid) begin
      rd_data_q.push_back(ic_rdata);
      rd_idx_q.push_back(int'(ic_widx));
    end
    if (dc_rvalid) dcv_seen = 1'b1;
    if (ic_done) begin
      seen_icd = 1'b1; ic_done_cyc = cyc; done_cnt++; done_order_q.push_back(1'b0);
    end
    if (dc_done) begin
      seen_dcd = 1'b1; done_cnt++; done_order_q.push_back(1'b1);
    end
    if (d_start_obs < 0 && mem_req && mem_addr[31:12] == 20'h3) d_start_obs = cyc;
    if (auto_drop && rst && ph == P_DONE) begin
      if (cur_d) dc_req = 1'b0;
      else ic_req = 1'b0;
    end
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic run_until(input bit want_d, input int budget, input string tag);
    int n;
    n = 0;
    seen_icd = 1'b0;
    seen_dcd = 1'b0;
    while (!(want_d ? seen_dcd : seen_icd) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(want_d ? seen_dcd : seen_icd), 64'h1);
  endtask

  task automatic clear_logs();
    ack_addr_q.delete();
    ack_idx_q.delete();
    rd_data_q.delete();
    rd_idx_q.delete();
    done_order_q.delete();
    we_acks  = 0;
    done_cnt = 0;
    dcv_seen = 1'b0;
    n_acks   = 0;
    alt      = 1'b0;
  endtask

  initial begin
    int b;
    rst = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    ack_mode = 0; rd_rand = 1'b0; rdata_base = 32'hA0; auto_drop = 1'b1;
    cyc = 0; d_start_obs = -1; ic_done_cyc = 0; last_ack_cyc = 0;
    model_reset();
    clear_logs();

    // Reset held: all outputs low.
    repeat (3) step();

    // Instruction fill; request present as reset releases.
    clear_logs();
    rdata_base = 32'hA0;
    ic_addr = 32'h104;
    ic_req  = 1'b1;
    rst     = 1'b1;
    run_until(1'b0, 40, "i_fill");
    chk("i_fill_len", 64'(ack_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("i_fill_addr", 64'(ack_addr_q[i]), 64'(32'h100 + 4 * i));
      chk("i_fill_data", 64'(rd_data_q[i]),  64'(32'hA0 + i));
      chk("i_fill_widx", 64'(rd_idx_q[i]),   64'(i));
    end
    chk("i_fill_done_lat", 64'(ic_done_cyc - last_ack_cyc), 64'd1);

    // Data write-back, ack every other cycle.
    clear_logs();
    ack_mode = 1;
    dc_addr  = 32'h2000;
    dc_we    = 1'b1;
    dc_req   = 1'b1;
    run_until(1'b1, 60, "wb");
    chk("wb_len", 64'(ack_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wb_addr", 64'(ack_addr_q[i]), 64'(32'h2000 + 4 * i));
      chk("wb_widx", 64'(ack_idx_q[i]),  64'(i));
    end
    chk("wb_we_words", 64'(we_acks), 64'd4);
    chk("wb_rvalid_seen", 64'(dcv_seen), 64'd0);

    // Simultaneous requests twice from a fresh reset: D, I, D.
    rst = 1'b0;
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    clear_logs();
    ack_mode = 2;
    dc_we   = 1'b0;
    ic_addr = 32'h400;
    dc_addr = 32'h800;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    run_until(1'b1, 80, "tie1_d");
    run_until(1'b0, 80, "tie1_i");
    ic_req = 1'b1;
    dc_req = 1'b1;
    run_until(1'b1, 80, "tie2_d");
    run_until(1'b0, 80, "tie2_i");
    chk("tie_order_0", 64'(done_order_q[0]), 64'd1);
    chk("tie_order_1", 64'(done_order_q[1]), 64'd0);
    chk("tie_order_2", 64'(done_order_q[2]), 64'd1);

    // Reset after 2 of 4 acks.
    clear_logs();
    ack_mode = 0;
    ic_addr  = 32'h600;
    ic_req   = 1'b1;
    b = 0;
    while (n_acks < 2 && b < 20) begin
      step();
      b++;
    end
    chk("rst_pre_acks", 64'(n_acks), 64'd2);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_async_mem_req",  64'(mem_req),   64'd0);
    chk("rst_async_mem_addr", 64'(mem_addr),  64'd0);
    chk("rst_async_ic_done",  64'(ic_done),   64'd0);
    chk("rst_async_stall",    64'(icache_stall), 64'd0);
    done_cnt = 0;
    repeat (3) step();
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    rst = 1'b1;
    ack_addr_q.delete();
    run_until(1'b0, 40, "rst_fresh");
    chk("rst_fresh_len",   64'(ack_addr_q.size()), 64'd4);
    chk("rst_fresh_addr0", 64'(ack_addr_q[0]), 64'h600);

    // Requester drops after word 1.
    clear_logs();
    ic_addr = 32'h700;
    ic_req  = 1'b1;
    b = 0;
    while (n_acks < 2 && b < 20) begin
      step();
      b++;
    end
    ic_req = 1'b0;
    run_until(1'b0, 40, "drop");
    chk("drop_words", 64'(ack_addr_q.size()), 64'd4);
    chk("drop_last_addr", 64'(ack_addr_q[3]), 64'h70C);

    // Data request arriving during an instruction burst.
    clear_logs();
    d_start_obs = -1;
    ic_addr = 32'h800;
    ic_req  = 1'b1;
    repeat (2) step();
    dc_we   = 1'b0;
    dc_addr = 32'h3010;
    dc_req  = 1'b1;
    run_until(1'b0, 40, "wait_i");
    run_until(1'b1, 40, "wait_d");
    chk("wait_grant_gap", 64'(d_start_obs - ic_done_cyc), 64'd2);

    // Randomized traffic.
    ack_mode = 2;
    rd_rand  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!ic_req && $urandom_range(0, 3) == 0) ic_req = 1'b1;
      if (!dc_req && $urandom_range(0, 3) == 0) dc_req = 1'b1;
      ic_addr = 32'($urandom);
      dc_addr = 32'($urandom);
      dc_we   = 1'($urandom_range(0, 1));
      step();
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
